pulse_height_uart_tx: RTL and testbench
=======================================

Name: pulse_height_uart_tx

Overview:
Consumer end of the pulse-height path. Accepts 16-bit pulse-height results from the optimal-filter calculator and buffers them in a small FIFO. Each result is framed as a 4-byte packet with sync and checksum, then serialized as UART 8N1 on the board TX pin toward the host PC.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200 baud); legal range >= 2.
FIFO_DEPTH, 4, result FIFO entries; power of two, >= 2.
SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  asynchronous, active-high reset.
ph_valid  in  1  one-cycle strobe: ph_data holds a new result.
ph_data  in  16  pulse height, unsigned.
tx  out  1  UART serial line; idles high.
busy  out  1  high while a frame is in flight or FIFO non-empty.
overflow  out  1  sticky: a result was dropped because FIFO was full.
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, active-high): tx=1, busy=0, overflow=0, fifo_count=0. FIFO pointers cleared, framer to IDLE, bit counters zeroed. Reset mid-frame drives tx high immediately and discards the partial frame and all queued data.
- Push: on a clk edge with ph_valid=1, ph_data is written if fifo_count<FIFO_DEPTH, or if a pop occurs the same cycle. Otherwise the data is dropped and overflow is set, remaining 1 until reset.
- Simultaneous push and pop: both take effect; fifo_count unchanged.
- Framer FSM: IDLE -> LOAD -> SEND_SYNC -> SEND_HI -> SEND_LO -> SEND_CHK -> IDLE.
  - IDLE: if FIFO is non-empty, pop the head into frame register (data_q) and go to LOAD.
  - LOAD: compute chk = SYNC_BYTE ^ data_q[15:8] ^ data_q[7:0]; start the byte serializer with SYNC_BYTE.
  - SEND_x: wait for serializer done, start the next byte (data_q[15:8], data_q[7:0], chk).
  - After the chk byte's done, return to IDLE.
- Byte serializer: start bit 0, data bits LSB first, stop bit 1. Each bit is exactly CLKS_PER_BIT cycles; one byte is 10*CLKS_PER_BIT cycles. The next byte's start bit begins the cycle after the previous stop bit ends, so there is no intra-frame gap.
- Latency: with FIFO empty and FSM in IDLE, ph_valid sampled at edge N gives write at N, pop at N+1, LOAD at N+2, and tx falls at edge N+3.
- Frame duration: 40*CLKS_PER_BIT cycles from tx fall to end of the last stop bit. Minimum inter-frame idle is 2 cycles (IDLE+LOAD).
- busy = (FSM != IDLE) | (fifo_count != 0), registered.
- ph_data is never read except on an accepted push; changes on non-valid cycles are ignored.
- Pointer wrap-around: read/write pointers wrap modulo FIFO_DEPTH. Full/empty are derived from fifo_count, not pointer equality.

Decomposition:
- Package pulse_tx_pkg:
  - frame_state_t enum (IDLE, LOAD, SEND_SYNC, SEND_HI, SEND_LO, SEND_CHK).
  - FRAME_BYTES=4.
  - Default SYNC_BYTE constant.
  - Checksum function (3-way XOR).
- Sub-module uart_byte_tx:
  - Ports: clk, reset, start, data[7:0], tx, ready, done.
  - Parameter CLKS_PER_BIT.
  - Contains the bit timer and 10-bit shift logic.
- The top holds the FIFO and framer FSM.

Test Plan:
Bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4.
1. Single push ph_data=16'h1234 when idle -> tx falls 3 cycles after strobe; bytes decoded A5,12,34,83; frame lasts 160 cycles; busy drops after the last stop bit; overflow=0.
2. Push 16'hFFFF -> bytes A5,FF,FF,A5 (checksum A5). Push 16'h0000 -> bytes A5,00,00,A5.
3. Six back-to-back ph_valid cycles with values 1..6 from idle -> value 1 is popped into the framer, values 2..5 fill the FIFO (fifo_count=4), value 6 is dropped and overflow=1. Serial output is frames for 1,2,3,4,5 in order, each separated by exactly 2 idle-high cycles.
4. FIFO full (count=4) and ph_valid coincident with the framer's IDLE pop -> push accepted, fifo_count stays 4, overflow stays 0.
5. Assert reset during bit 3 of SEND_HI with 2 entries queued -> tx=1 on the same cycle, fifo_count=0, busy=0, overflow=0. A subsequent push of 16'hABCD yields a clean frame A5,AB,CD,C3.
6. Bit-timing check: sample tx at every bit centre over a frame of 16'h5A5A; every bit level is held exactly 4 cycles; stop bits are high; no glitches.

Source files
------------

// File: rtl/pulse_tx_pkg.sv
// Shared types and constants for the pulse-height UART transmit path.
package pulse_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND_SYNC,
        SEND_HI,
        SEND_LO,
        SEND_CHK
    } frame_state_t;

    localparam int         FRAME_BYTES       = 4;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    function automatic logic [7:0] frame_checksum(input logic [7:0] sync,
                                                  input logic [7:0] hi,
                                                  input logic [7:0] lo);
        return sync ^ hi ^ lo;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// UART 8N1 byte serializer: start bit, eight data bits LSB first, stop bit.
// ready is also high in the stop bit's final cycle so consecutive bytes abut.
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready,
    output logic       done
);

    localparam int             CW         = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  LAST_TICK  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  EARLY_TICK = CW'(CLKS_PER_BIT - 2);

    logic          active_q;
    logic [CW-1:0] tick_q;
    logic [3:0]    bit_q;
    logic [8:0]    shift_q;
    logic          tx_q;
    logic          last_bit;
    logic          bit_end;

    assign last_bit = (bit_q == 4'd9);
    assign bit_end  = active_q && (tick_q == LAST_TICK);
    assign ready    = !active_q || (bit_end && last_bit);
    // done leads the end of the stop bit by one cycle so the framer can overlap its IDLE step.
    assign done     = active_q && last_bit && (tick_q == EARLY_TICK);
    assign tx       = tx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
        end else if (start && ready) begin
            active_q <= 1'b1;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= {1'b1, data};
            tx_q     <= 1'b0;
        end else if (active_q) begin
            if (tick_q == LAST_TICK) begin
                tick_q <= '0;
                if (last_bit) begin
                    active_q <= 1'b0;
                    bit_q    <= '0;
                    tx_q     <= 1'b1;
                end else begin
                    tx_q    <= shift_q[0];
                    shift_q <= {1'b0, shift_q[8:1]};
                    bit_q   <= bit_q + 4'd1;
                end
            end else begin
                tick_q <= tick_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_height_uart_tx.sv
// Result FIFO plus framer: each 16-bit pulse height goes out as SYNC, HI, LO, CHK
// over UART 8N1 with no gaps between the bytes of one frame.
module pulse_height_uart_tx
    import pulse_tx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ph_valid,
    input  logic [15:0]                 ph_data,
    output logic                        tx,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int            AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;

    frame_state_t  state_q;
    logic [15:0]   data_q;
    logic [7:0]    chk_q;
    logic [7:0]    byte_q;
    logic          start_q;
    logic          busy_q;

    logic          pop;
    logic          push;
    logic          ser_tx;
    logic          ser_ready;
    logic          ser_done;
    logic          accept;

    // A full FIFO still takes a push when the framer drains the head on the same edge.
    assign pop    = (state_q == IDLE) && (count_q != '0);
    assign push   = ph_valid && ((count_q != FULL_COUNT) || pop);
    assign accept = start_q && ser_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (ph_valid && !push) begin
            ovf_d = 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ph_data;
        end
    end

    // start_q stays high across a frame; each accepted byte immediately stages the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            chk_q   <= '0;
            byte_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            busy_q <= (state_q != IDLE) || (count_q != '0);
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        data_q  <= mem_q[rd_ptr_q];
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    chk_q   <= frame_checksum(SYNC_BYTE, data_q[15:8], data_q[7:0]);
                    byte_q  <= SYNC_BYTE;
                    start_q <= 1'b1;
                    state_q <= SEND_SYNC;
                end
                SEND_SYNC: begin
                    if (accept) begin
                        byte_q  <= data_q[15:8];
                        state_q <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (accept) begin
                        byte_q  <= data_q[7:0];
                        state_q <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (accept) begin
                        byte_q  <= chk_q;
                        state_q <= SEND_CHK;
                    end
                end
                SEND_CHK: begin
                    if (start_q) begin
                        if (accept) begin
                            start_q <= 1'b0;
                        end
                    end else if (ser_done) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    start_q <= 1'b0;
                end
            endcase
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk  (clk),
        .reset(reset),
        .start(start_q),
        .data (byte_q),
        .tx   (ser_tx),
        .ready(ser_ready),
        .done (ser_done)
    );

    assign tx         = ser_tx;
    assign busy       = busy_q;
    assign overflow   = ovf_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_pulse_height_uart_tx.sv
// Bench for pulse_height_uart_tx: a UART receiver decodes tx, tests compare
// decoded bytes and their start cycles against frames derived from the pushed values.
module tb_pulse_height_uart_tx;
    import pulse_tx_pkg::*;

    localparam int CPB       = 4;
    localparam int DEPTH     = 4;
    localparam int BYTE_CYC  = 10 * CPB;
    localparam int FRAME_CYC = FRAME_BYTES * BYTE_CYC;
    localparam int GAP       = FRAME_CYC + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ph_valid = 1'b0;
    logic [15:0] ph_data = '0;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [2:0]  fifo_count;

    int          cyc = 0;
    int          checks = 0;
    int          passed = 0;
    int          mon_err = 0;
    logic [7:0]  rx_q [$];
    int          rx_t [$];
    logic [15:0] bv [8];

    pulse_height_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ph_valid  (ph_valid),
        .ph_data   (ph_data),
        .tx        (tx),
        .busy      (busy),
        .overflow  (overflow),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver: every cycle of every bit is sampled; an unstable bit or bad framing counts an error.
    initial begin
        logic [CPB-1:0] samp;
        logic [7:0]     byte_v;
        logic           lvl;
        bit             bad;
        int             b_start;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                b_start = cyc;
                bad     = 1'b0;
                byte_v  = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (!(b == 0 && c == 0)) @(negedge clk);
                        samp[c] = tx;
                    end
                    lvl = samp[CPB/2];
                    for (int c = 0; c < CPB; c++) if (samp[c] !== lvl) bad = 1'b1;
                    if (b == 0 && lvl !== 1'b0) bad = 1'b1;
                    if (b >= 1 && b <= 8) byte_v[b-1] = lvl;
                    if (b == 9 && lvl !== 1'b1) bad = 1'b1;
                end
                rx_q.push_back(byte_v);
                rx_t.push_back(b_start);
                if (bad) mon_err++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] exp_byte(input logic [15:0] v, input int k);
        case (k)
            0:       return 8'hA5;
            1:       return v[15:8];
            2:       return v[7:0];
            default: return 8'hA5 ^ v[15:8] ^ v[7:0];
        endcase
    endfunction

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_burst(input int n, output int first_edge);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ph_valid = 1'b1;
            ph_data  = bv[i];
        end
        @(negedge clk);
        ph_valid   = 1'b0;
        ph_data    = 16'($urandom);
        first_edge = cyc - n + 1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #3;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0 || fifo_count !== 3'd0)
            $display("[TB] FAIL reset_state: tx=%b busy=%b ovf=%b cnt=%0d required 1 0 0 0",
                     tx, busy, overflow, fifo_count);
        else passed++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int e, s, base, eb;
        base = rx_q.size();
        eb   = mon_err;
        bv[0] = 16'h1234;
        push_burst(1, e);
        s = e + 3;
        wait_until(s + FRAME_CYC - 1);
        checks++;
        if (busy !== 1'b1) $display("[TB] FAIL single_busy_last_stop: busy=%b required 1", busy);
        else passed++;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1 || overflow !== 1'b0 || fifo_count !== 3'd0)
            $display("[TB] FAIL single_after: busy=%b tx=%b ovf=%b cnt=%0d required 0 1 0 0",
                     busy, tx, overflow, fifo_count);
        else passed++;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (base + k >= rx_q.size())
                $display("[TB] FAIL single_byte%0d: missing, required %h", k, exp_byte(bv[0], k));
            else if (rx_q[base+k] !== exp_byte(bv[0], k) || rx_t[base+k] !== s + k * BYTE_CYC)
                $display("[TB] FAIL single_byte%0d: got %h at %0d required %h at %0d", k,
                         rx_q[base+k], rx_t[base+k], exp_byte(bv[0], k), s + k * BYTE_CYC);
            else passed++;
        end
        checks++;
        if (mon_err !== eb) $display("[TB] FAIL single_framing: errors %0d required %0d", mon_err, eb);
        else passed++;
    endtask

    task automatic test_checksum_extremes();
        logic [15:0] vals [2];
        int e, s, base;
        vals[0] = 16'hFFFF;
        vals[1] = 16'h0000;
        for (int j = 0; j < 2; j++) begin
            base  = rx_q.size();
            bv[0] = vals[j];
            push_burst(1, e);
            s = e + 3;
            wait_until(s + FRAME_CYC + 1);
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (base + k >= rx_q.size())
                    $display("[TB] FAIL extreme_%h_byte%0d: missing", vals[j], k);
                else if (rx_q[base+k] !== exp_byte(vals[j], k) || rx_t[base+k] !== s + k * BYTE_CYC)
                    $display("[TB] FAIL extreme_%h_byte%0d: got %h at %0d required %h at %0d",
                             vals[j], k, rx_q[base+k], rx_t[base+k], exp_byte(vals[j], k),
                             s + k * BYTE_CYC);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int e, s, base, idx;
        base = rx_q.size();
        for (int i = 0; i < 6; i++) bv[i] = 16'(i + 1);
        push_burst(6, e);
        s = e + 3;
        checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b1)
            $display("[TB] FAIL b2b_overflow: cnt=%0d ovf=%b required 4 1", fifo_count, overflow);
        else passed++;
        wait_until(s + 4 * GAP + FRAME_CYC + 1);
        for (int j = 0; j < 5; j++) begin
            for (int k = 0; k < 4; k++) begin
                idx = base + j * 4 + k;
                checks++;
                if (idx >= rx_q.size())
                    $display("[TB] FAIL b2b_f%0d_b%0d: missing", j, k);
                else if (rx_q[idx] !== exp_byte(bv[j], k) || rx_t[idx] !== s + j * GAP + k * BYTE_CYC)
                    $display("[TB] FAIL b2b_f%0d_b%0d: got %h at %0d required %h at %0d", j, k,
                             rx_q[idx], rx_t[idx], exp_byte(bv[j], k), s + j * GAP + k * BYTE_CYC);
                else passed++;
            end
        end
        checks++;
        if (rx_q.size() !== base + 20)
            $display("[TB] FAIL b2b_count: got %0d bytes required %0d", rx_q.size() - base, 20);
        else passed++;
    endtask

    task automatic test_full_pop();
        int e, s, base, idx;
        apply_reset();
        base = rx_q.size();
        for (int i = 0; i < 6; i++) bv[i] = 16'($urandom);
        push_burst(5, e);
        s = e + 3;
        checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0)
            $display("[TB] FAIL fullpop_fill: cnt=%0d ovf=%b required 4 0", fifo_count, overflow);
        else passed++;
        wait_until(s + FRAME_CYC - 1);
        ph_valid = 1'b1;
        ph_data  = bv[5];
        @(negedge clk);
        ph_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0)
            $display("[TB] FAIL fullpop_coincident: cnt=%0d ovf=%b required 4 0", fifo_count, overflow);
        else passed++;
        wait_until(s + 5 * GAP + FRAME_CYC + 1);
        for (int j = 0; j < 6; j++) begin
            for (int k = 0; k < 4; k++) begin
                idx = base + j * 4 + k;
                checks++;
                if (idx >= rx_q.size())
                    $display("[TB] FAIL fullpop_f%0d_b%0d: missing", j, k);
                else if (rx_q[idx] !== exp_byte(bv[j], k) || rx_t[idx] !== s + j * GAP + k * BYTE_CYC)
                    $display("[TB] FAIL fullpop_f%0d_b%0d: got %h at %0d required %h at %0d", j, k,
                             rx_q[idx], rx_t[idx], exp_byte(bv[j], k), s + j * GAP + k * BYTE_CYC);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_midframe();
        int e, s, base, eb;
        bv[0] = 16'h1100;
        bv[1] = 16'($urandom);
        bv[2] = 16'($urandom);
        push_burst(3, e);
        s = e + 3;
        wait_until(s + BYTE_CYC + 3 * CPB + 1);
        checks++;
        if (tx !== 1'b0 || fifo_count !== 3'd2)
            $display("[TB] FAIL midframe_pre: tx=%b cnt=%0d required 0 2", tx, fifo_count);
        else passed++;
        reset = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0 || overflow !== 1'b0)
            $display("[TB] FAIL midframe_reset: tx=%b cnt=%0d busy=%b ovf=%b required 1 0 0 0",
                     tx, fifo_count, busy, overflow);
        else passed++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        base  = rx_q.size();
        eb    = mon_err;
        bv[0] = 16'hABCD;
        push_burst(1, e);
        s = e + 3;
        wait_until(s + FRAME_CYC + 1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (base + k >= rx_q.size())
                $display("[TB] FAIL postreset_byte%0d: missing", k);
            else if (rx_q[base+k] !== exp_byte(bv[0], k) || rx_t[base+k] !== s + k * BYTE_CYC)
                $display("[TB] FAIL postreset_byte%0d: got %h at %0d required %h at %0d", k,
                         rx_q[base+k], rx_t[base+k], exp_byte(bv[0], k), s + k * BYTE_CYC);
            else passed++;
        end
        checks++;
        if (mon_err !== eb || rx_q.size() !== base + 4)
            $display("[TB] FAIL postreset_clean: errors %0d bytes %0d required %0d and 4",
                     mon_err, rx_q.size() - base, eb);
        else passed++;
    endtask

    task automatic test_bit_timing();
        int e, s, base, eb;
        base  = rx_q.size();
        eb    = mon_err;
        bv[0] = 16'h5A5A;
        push_burst(1, e);
        s = e + 3;
        wait_until(s + FRAME_CYC + 1);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (base + k >= rx_q.size())
                $display("[TB] FAIL timing_byte%0d: missing", k);
            else if (rx_q[base+k] !== exp_byte(bv[0], k) || rx_t[base+k] !== s + k * BYTE_CYC)
                $display("[TB] FAIL timing_byte%0d: got %h at %0d required %h at %0d", k,
                         rx_q[base+k], rx_t[base+k], exp_byte(bv[0], k), s + k * BYTE_CYC);
            else passed++;
        end
        checks++;
        if (mon_err !== eb)
            $display("[TB] FAIL timing_stability: bad bits/stop in %0d bytes required 0", mon_err - eb);
        else passed++;
    endtask

    task automatic test_random();
        int e, s, base, idx, n, exp_cnt;
        for (int r = 0; r < 4; r++) begin
            n    = $urandom_range(1, 4);
            base = rx_q.size();
            for (int i = 0; i < n; i++) bv[i] = 16'($urandom);
            push_burst(n, e);
            s = e + 3;
            exp_cnt = (n == 1) ? 1 : n - 1;
            checks++;
            if (fifo_count !== 3'(exp_cnt))
                $display("[TB] FAIL random%0d_count: cnt=%0d required %0d", r, fifo_count, exp_cnt);
            else passed++;
            wait_until(s + (n - 1) * GAP + FRAME_CYC + 1);
            for (int j = 0; j < n; j++) begin
                for (int k = 0; k < 4; k++) begin
                    idx = base + j * 4 + k;
                    checks++;
                    if (idx >= rx_q.size())
                        $display("[TB] FAIL random%0d_f%0d_b%0d: missing", r, j, k);
                    else if (rx_q[idx] !== exp_byte(bv[j], k) ||
                             rx_t[idx] !== s + j * GAP + k * BYTE_CYC)
                        $display("[TB] FAIL random%0d_f%0d_b%0d: got %h at %0d required %h at %0d",
                                 r, j, k, rx_q[idx], rx_t[idx], exp_byte(bv[j], k),
                                 s + j * GAP + k * BYTE_CYC);
                    else passed++;
                end
            end
            checks++;
            if (busy !== 1'b0 || overflow !== 1'b0)
                $display("[TB] FAIL random%0d_idle: busy=%b ovf=%b required 0 0", r, busy, overflow);
            else passed++;
        end
    endtask

    initial begin
        $display("[TB] starting pulse_height_uart_tx bench");
        test_reset();
        test_single();
        test_checksum_extremes();
        test_back_to_back();
        test_full_pop();
        test_reset_midframe();
        test_bit_timing();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
